// File: rtl/obj_pkg.sv
// Purpose: shared constants, state encoding and the per-frame aging rule for the object table.
// Latency: n/a (package only).
// Backpressure: n/a.
package obj_pkg;

    localparam int NUM_SLOTS = 5;
    localparam int OBJ_W     = 26;

    // Slot word layout: {frame, id, hpos, vpos}; all-zero means empty.
    localparam int FRAME_MSB = 25;
    localparam int FRAME_LSB = 23;
    localparam int ID_MSB    = 22;
    localparam int ID_LSB    = 21;
    localparam int HPOS_MSB  = 20;
    localparam int HPOS_LSB  = 10;
    localparam int VPOS_MSB  = 9;
    localparam int VPOS_LSB  = 0;

    localparam logic [1:0] ID_COLL  = 2'd0;
    localparam logic [1:0] ID_SHARK = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_SPAWN  = 2'd2
    } state_t;

    // One frame of aging for a single slot. Retirement is tested before the
    // subtraction so hpos can never wrap around.
    function automatic logic [OBJ_W-1:0] obj_age(
        input logic [OBJ_W-1:0] word,
        input logic             kill,
        input logic             wrap,
        input logic [10:0]      step
    );
        logic [OBJ_W-1:0] r;
        r = word;
        if (word == '0) begin
            r = '0;
        end else if (kill) begin
            r = '0;
        end else if (word[HPOS_MSB:HPOS_LSB] < step) begin
            r = '0;
        end else begin
            r[HPOS_MSB:HPOS_LSB] = word[HPOS_MSB:HPOS_LSB] - step;
            if (wrap) begin
                r[FRAME_MSB:FRAME_LSB] = word[FRAME_MSB:FRAME_LSB] + 3'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Purpose: two-requester round-robin arbiter; rr_ptr names the requester that wins a tie.
// Latency: grants combinational from req/en; rr_ptr updates on the clock after a contested grant.
// Backpressure: no grant while en is low; requests simply wait.
// Ports: vclock/reset (sync, active-high), en, req0/req1 in; gnt0/gnt1 out.
module rr_arbiter2 (
    input  logic vclock,
    input  logic reset,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie.
    logic rr_ptr;

    assign gnt0 = en & req0 & (~req1 | ~rr_ptr);
    assign gnt1 = en & req1 & (~req0 |  rr_ptr);

    // After a contested grant the pointer moves to the loser.
    always_ff @(posedge vclock) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (en && req0 && req1) begin
            rr_ptr <= ~rr_ptr;
        end
    end

endmodule

// File: rtl/obj_scheduler.sv
// Purpose: per-frame object table: scroll/animate/retire live slots, apply kills, grant one spawn.
// Latency: vsync fall detected at t; slots t+1..t+5, ack at t+6, new slot word and obj_count at t+7.
// Backpressure: spawn requests are held (level) until acked; no ack while the table is full.
// Ports: vclock/reset, vsync, coll_* and shark_* spawn handshakes, hit_valid/hit_slot kills,
//        p_obj1..p_obj5 slot words, obj_count, busy.
module obj_scheduler
    import obj_pkg::*;
#(
    parameter int SCROLL_STEP = 2,
    parameter int ANIM_DIV    = 4,
    parameter int SPAWN_X     = 1023
) (
    input  logic        vclock,
    input  logic        reset,
    input  logic        vsync,
    input  logic        coll_req,
    input  logic [9:0]  coll_vpos,
    output logic        coll_ack,
    input  logic        shark_req,
    input  logic [9:0]  shark_vpos,
    output logic        shark_ack,
    input  logic        hit_valid,
    input  logic [2:0]  hit_slot,
    output logic [25:0] p_obj1,
    output logic [25:0] p_obj2,
    output logic [25:0] p_obj3,
    output logic [25:0] p_obj4,
    output logic [25:0] p_obj5,
    output logic [2:0]  obj_count,
    output logic        busy
);

    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [2:0] LAST_IDX = 3'(NUM_SLOTS - 1);

    state_t               state;
    logic                 vsync_d;
    logic                 frame_edge;
    logic [2:0]           slot_idx;
    logic [OBJ_W-1:0]     slot_q   [NUM_SLOTS];
    logic [OBJ_W-1:0]     slot_nxt [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] kill_mask;
    logic [NUM_SLOTS-1:0] kill_nxt;
    logic [AW-1:0]        anim_cnt;
    logic                 anim_wrap;

    // Spawn decided at the end of the last UPDATE cycle, written during SPAWN.
    logic                 pend_vld;
    logic [2:0]           pend_idx;
    logic [OBJ_W-1:0]     pend_word;

    logic                 free_found;
    logic [2:0]           free_idx;
    logic                 last_upd;
    logic                 arb_en;
    logic                 gnt_c;
    logic                 gnt_s;
    logic [2:0]           cnt_nxt;

    assign frame_edge = vsync_d & ~vsync;
    assign last_upd   = (state == ST_UPDATE) && (slot_idx == LAST_IDX);

    // Next value of every slot: aging for the visited slot, spawn write in SPAWN.
    always_comb begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_nxt[k] = slot_q[k];
            if (state == ST_UPDATE && slot_idx == 3'(k)) begin
                slot_nxt[k] = obj_age(slot_q[k], kill_mask[k], anim_wrap, 11'(SCROLL_STEP));
            end
            if (state == ST_SPAWN && pend_vld && pend_idx == 3'(k)) begin
                slot_nxt[k] = pend_word;
            end
        end
    end

    // Free-slot search looks at post-update contents, so a slot emptied on
    // the final UPDATE cycle is already eligible for this frame's spawn.
    always_comb begin
        free_found = 1'b0;
        free_idx   = 3'd0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (slot_nxt[k] == '0) begin
                free_found = 1'b1;
                free_idx   = 3'(k);
            end
        end
    end

    always_comb begin
        cnt_nxt = 3'd0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_nxt[k] != '0) begin
                cnt_nxt = cnt_nxt + 3'd1;
            end
        end
    end

    // Visit and spawn clear a bit first; a new hit in the same cycle wins
    // so it is not lost and lands on the next pass.
    always_comb begin
        kill_nxt = kill_mask;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (state == ST_UPDATE && slot_idx == 3'(k)) begin
                kill_nxt[k] = 1'b0;
            end
            if (state == ST_SPAWN && pend_vld && pend_idx == 3'(k)) begin
                kill_nxt[k] = 1'b0;
            end
            if (hit_valid && hit_slot == 3'(k)) begin
                kill_nxt[k] = 1'b1;
            end
        end
    end

    assign arb_en = last_upd && free_found;

    rr_arbiter2 u_arb (
        .vclock (vclock),
        .reset  (reset),
        .en     (arb_en),
        .req0   (coll_req),
        .req1   (shark_req),
        .gnt0   (gnt_c),
        .gnt1   (gnt_s)
    );

    always_ff @(posedge vclock) begin
        if (reset) begin
            state     <= ST_IDLE;
            vsync_d   <= 1'b1;
            slot_idx  <= 3'd0;
            kill_mask <= '0;
            anim_cnt  <= '0;
            anim_wrap <= 1'b0;
            pend_vld  <= 1'b0;
            pend_idx  <= 3'd0;
            pend_word <= '0;
            coll_ack  <= 1'b0;
            shark_ack <= 1'b0;
            obj_count <= 3'd0;
            busy      <= 1'b0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            vsync_d   <= vsync;
            kill_mask <= kill_nxt;
            coll_ack  <= 1'b0;
            shark_ack <= 1'b0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_q[k] <= slot_nxt[k];
            end

            case (state)
                ST_IDLE: begin
                    if (frame_edge) begin
                        state    <= ST_UPDATE;
                        slot_idx <= 3'd0;
                        busy     <= 1'b1;
                        if (anim_cnt == AW'(ANIM_DIV - 1)) begin
                            anim_cnt  <= '0;
                            anim_wrap <= 1'b1;
                        end else begin
                            anim_cnt  <= anim_cnt + 1'b1;
                            anim_wrap <= 1'b0;
                        end
                    end
                end
                ST_UPDATE: begin
                    slot_idx <= slot_idx + 3'd1;
                    if (last_upd) begin
                        state     <= ST_SPAWN;
                        pend_vld  <= gnt_c | gnt_s;
                        pend_idx  <= free_idx;
                        pend_word <= {3'd0, (gnt_s ? ID_SHARK : ID_COLL), 11'(SPAWN_X),
                                      (gnt_s ? shark_vpos : coll_vpos)};
                        coll_ack  <= gnt_c;
                        shark_ack <= gnt_s;
                    end
                end
                ST_SPAWN: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    pend_vld  <= 1'b0;
                    obj_count <= cnt_nxt;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign p_obj1 = slot_q[0];
    assign p_obj2 = slot_q[1];
    assign p_obj3 = slot_q[2];
    assign p_obj4 = slot_q[3];
    assign p_obj5 = slot_q[4];

endmodule

// File: doc/obj_scheduler.md
# obj_scheduler

Owns the on-screen object table that feeds the display's five packed object inputs p_obj1..p_obj5. Once per video frame, at the falling edge of vsync, it scrolls every live object left, advances sprite animation and retires objects that leave the screen. It then arbitrates spawn requests from the collectable and shark generators into free slots, and clears slots on collision reports from game logic.

## Interface
- NUM_SLOTS, 5: object slots; the port list is fixed at 5.
- SCROLL_STEP, 2: pixels of leftward motion per frame.
- ANIM_DIV, 4: frames per animation-frame increment.
- SPAWN_X, 1023: hpos assigned to new objects; must be nonzero.
- vclock  in  1  65 MHz pixel clock
- reset  in  1  reset, synchronous, active-high
- vsync  in  1  active-low vertical sync, synchronous to vclock
- coll_req / coll_vpos  in  1 / 10  collectable spawn request, level; vertical position
- coll_ack  out  1  one-cycle grant pulse
- shark_req / shark_vpos  in  1 / 10  shark spawn request, level; vertical position
- shark_ack  out  1  one-cycle grant pulse
- hit_valid / hit_slot  in  1 / 3  kill request for slot index 0..4
- p_obj1..p_obj5  out  26  slot words: [25:23] anim frame, [22:21] identity (0 collectable, 1 shark), [20:10] hpos, [9:0] vpos. All-zero means empty.
- obj_count  out  3  number of live slots
- busy  out  1  high while in UPDATE or SPAWN

## Operation
- Frame edge: vsync_d is registered. An edge is `vsync_d==1 && vsync==0`. vsync_d resets to 1.
- FSM states: IDLE, UPDATE, SPAWN.
  - IDLE→UPDATE on a frame edge.
  - UPDATE visits slot k = 0..NUM_SLOTS-1, one slot per cycle.
  - After the last slot, the FSM goes to SPAWN for 1 cycle, then to IDLE.
  - Frame edges outside IDLE are ignored.
- UPDATE, per live slot k, in priority order:
  - If kill_mask[k] is set, the slot becomes 0.
  - Else if hpos < SCROLL_STEP, the slot becomes 0 (retired).
  - Else hpos -= SCROLL_STEP. If anim_wrap is set, frame = frame+1 mod 8.
  - Empty slots stay 0.
  - kill_mask[k] clears when slot k is visited.
- anim_cnt counts frame edges modulo ANIM_DIV. anim_wrap is set for the frame in which anim_cnt rolls over to 0.
- Kill:
  - hit_valid with hit_slot < NUM_SLOTS sets kill_mask[hit_slot] in any state; the slot is applied on the next UPDATE pass.
  - hit_slot ≥ NUM_SLOTS is ignored.
  - A hit on an empty slot has no effect.
- SPAWN:
  - Target is the lowest-index empty slot.
  - If either req is high and a slot is free, exactly one requester is granted:
    - If only one requests, that one wins.
    - If both request, rr_ptr selects the winner, and rr_ptr then points at the loser.
  - The granted slot is loaded with {3'd0, id, SPAWN_X, vpos}. Its kill_mask bit is cleared.
  - The matching ack pulses for this cycle.
  - With no free slot, no ack is issued and requests wait.
- At most one spawn per frame.
- Requesters hold req and vpos stable until ack, then drop req or present the next request.

## Timing
- Edge detected at cycle t: UPDATE occupies t+1..t+5, SPAWN is t+6, IDLE from t+7.
- p_obj outputs are the slot registers directly, with no extra stage. Updates complete about 7 cycles after the vsync fall, well before the display's next-frame sample.
- ack is registered and asserted in the SPAWN cycle. The slot word is visible the following cycle.
- obj_count is recomputed registered on entry to IDLE.
- Reset values: all p_obj = 0, acks 0, busy 0, obj_count 0, state IDLE, anim_cnt 0, kill_mask 0, rr_ptr = collectable.
- Reset mid-UPDATE/SPAWN aborts the pass. The pending request is not acked and all slots clear.
- hpos arithmetic is 11-bit unsigned. Retirement is checked before subtraction, so no wrap-around is possible.

## Structure
- Package obj_pkg holds:
  - Field slice constants FRAME_MSB/LSB, ID_MSB/LSB, HPOS_MSB/LSB, VPOS_MSB/LSB.
  - ID_COLL=2'd0, ID_SHARK=2'd1.
  - State encoding for IDLE/UPDATE/SPAWN.
- Sub-module rr_arbiter2: a 2-requester round-robin arbiter with grant outputs and an rr_ptr register.
- Free-slot priority encoder and kill mask stay inline.

## Test plan
- Reset, then one frame edge with no requests → all p_obj 0, obj_count 0, busy high for exactly 6 cycles.
- coll_req=1, coll_vpos=300 → coll_ack at t+6; p_obj1=={3'd0,2'd0,11'd1023,10'd300}. After the next edge, hpos=1021.
- Both reqs held across 3 frames → grants alternate coll, shark, coll into slots 0, 1, 2; shark slot identity=1.
- Fill 5 slots, then shark_req → no ack while full. hit_valid slot 2 → slot 2 clears at next UPDATE; shark spawns into slot 2 in the same frame's SPAWN.
- Object at hpos=3 → next frame hpos=1, following frame retired to 0, obj_count decrements.
- ANIM_DIV=4, one live object → frame field increments every 4th edge and wraps 7→0. Reset asserted at t+3 of an UPDATE pass → all outputs 0 next cycle, no ack.
